// File: rtl/image_scan_ctrl.sv
// rtl/image_scan_ctrl.sv - scan sequencer feeding the image ALU stage
//
// Walks the output-unit grid for the selected scaling algorithm, presents
// source-RAM read addresses with row/col coordinates, enables the ALU per
// unit and waits for unit_done before advancing.
//
// Optional feature macro: SCAN_WATCHDOG_EN (RUN-state watchdog, WDOG_CYCLES).
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start            frame request, accepted only in IDLE
//   algo_sel         0 block avg, 1 NN zoom-in, 2 NN zoom-out, 3 replication
//   factor           scale factor F
//   src_width/height source image dimensions W/H
//   unit_done        ALU finished current unit (only honoured in RUN)
//   rom_addr         source RAM read address (RAM latency 1 cycle)
//   row, col         current unit coordinates
//   enable           ALU processing enable
//   busy             frame in progress
//   frame_done       one-cycle pulse at end of frame
//   error            sticky config/watchdog error, cleared on accepted start
module image_scan_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DIM_W       = 10,
  parameter int FACT_W      = 4,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        algo_sel,
  input  logic [FACT_W-1:0] factor,
  input  logic [DIM_W-1:0]  src_width,
  input  logic [DIM_W-1:0]  src_height,
  input  logic              unit_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              enable,
  output logic              busy,
  output logic              frame_done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ADDR, S_RUN, S_GAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          algo_q, algo_d;
  logic [FACT_W-1:0]   fact_q, fact_d;
  logic [DIM_W-1:0]    w_q, w_d, h_q, h_d;
  logic [ADDR_W-1:0]   gw_q, gw_d, gh_q, gh_d;
  logic [ADDR_W-1:0]   row_q, row_d, col_q, col_d;
  logic [FACT_W-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic                error_q, error_d;

`ifdef SCAN_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
`endif

  localparam logic [FACT_W-1:0] F_ONE = FACT_W'(1);

  logic [ADDR_W-1:0] f_ext, f_div, w_ext, h_ext;
  logic [ADDR_W-1:0] gw_calc, gh_calc, addr_calc;

  // Grid size and address arithmetic, all at ADDR_W width.
  always_comb begin
    f_ext = ADDR_W'(fact_q);
    // Divisor is forced non-zero; F==0 is rejected in SETUP anyway.
    f_div = (fact_q == '0) ? ADDR_W'(1) : f_ext;
    w_ext = ADDR_W'(w_q);
    h_ext = ADDR_W'(h_q);
    case (algo_q)
      2'd1:    begin gw_calc = w_ext * f_ext; gh_calc = h_ext * f_ext; end
      2'd3:    begin gw_calc = w_ext;         gh_calc = h_ext;         end
      default: begin gw_calc = w_ext / f_div; gh_calc = h_ext / f_div; end
    endcase
    case (algo_q)
      2'd0:    addr_calc = (row_q * f_ext + ADDR_W'(dy_q)) * w_ext
                           + col_q * f_ext + ADDR_W'(dx_q);
      2'd1:    addr_calc = (row_q / f_div) * w_ext + col_q / f_div;
      2'd2:    addr_calc = (row_q * f_ext) * w_ext + col_q * f_ext;
      default: addr_calc = row_q * w_ext + col_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    algo_d  = algo_q;
    fact_d  = fact_q;
    w_d     = w_q;
    h_d     = h_q;
    gw_d    = gw_q;
    gh_d    = gh_q;
    row_d   = row_q;
    col_d   = col_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    error_d = error_q;
`ifdef SCAN_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif
    // Block pixel walk: advances in ADDR too, so the address presented in
    // RUN cycle k is pixel k while the RAM returns pixel k-1. Holds at the
    // last pixel of the block.
    if (state_q == S_ADDR || state_q == S_RUN) begin
      if (dx_q != fact_q - F_ONE) begin
        dx_d = dx_q + F_ONE;
      end else if (dy_q != fact_q - F_ONE) begin
        dx_d = '0;
        dy_d = dy_q + F_ONE;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          algo_d  = algo_sel;
          fact_d  = factor;
          w_d     = src_width;
          h_d     = src_height;
          row_d   = '0;
          col_d   = '0;
          dx_d    = '0;
          dy_d    = '0;
          error_d = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (fact_q == '0) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          gw_d    = gw_calc;
          gh_d    = gh_calc;
          state_d = (gw_calc == '0 || gh_calc == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
`ifdef SCAN_WATCHDOG_EN
        wdog_d  = '0;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        if (unit_done) begin
          state_d = S_GAP;
        end
`ifdef SCAN_WATCHDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      S_GAP: begin
        dx_d = '0;
        dy_d = '0;
        if (row_q == gh_q - ADDR_W'(1) && col_q == gw_q - ADDR_W'(1)) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_DONE;
        end else begin
          if (col_q == gw_q - ADDR_W'(1)) begin
            col_d = '0;
            row_d = row_q + ADDR_W'(1);
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
          state_d = S_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      algo_q  <= '0;
      fact_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      gw_q    <= '0;
      gh_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      error_q <= 1'b0;
`ifdef SCAN_WATCHDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      algo_q  <= algo_d;
      fact_q  <= fact_d;
      w_q     <= w_d;
      h_q     <= h_d;
      gw_q    <= gw_d;
      gh_q    <= gh_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      error_q <= error_d;
`ifdef SCAN_WATCHDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign rom_addr   = addr_calc;
  assign row        = row_q;
  assign col        = col_q;
  assign enable     = (state_q == S_RUN);
  assign busy       = (state_q == S_SETUP) || (state_q == S_ADDR) ||
                      (state_q == S_RUN)   || (state_q == S_GAP);
  assign frame_done = (state_q == S_DONE);
  assign error      = error_q;

endmodule
